// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared defines, register file widths and sweep FSM state type
//
// Purpose : shared defines used across the decoder/writeback/register-file
//           slice, plus the package that carries the register file's widths
//           and FSM state type.
// Ports   : none (package and defines only).

`ifndef REGS_SHARED_DEFINES
`define REGS_SHARED_DEFINES
`define RADDR_WIDTH   5
`define RDATA_WIDTH   32
`define ZERO          32'h0000_0000
`define ZERO_REG      5'h00
`define WRITE_ENABLE  1'b1
`define WRITE_DISABLE 1'b0
`define READ_ENABLE   1'b1
`define READ_DISABLE  1'b0
`define REGS_IDLE     1'b0
`define REGS_CLEAR    1'b1
`endif

package regs_pkg;

  localparam int ADDR_W = `RADDR_WIDTH;
  localparam int DATA_W = `RDATA_WIDTH;

  typedef enum logic {
    IDLE  = `REGS_IDLE,
    CLEAR = `REGS_CLEAR
  } state_t;

endpackage

// File: rtl/regs_rport.sv
// rtl/regs_rport.sv - one combinational register file read port
//
// Purpose : selects the stored value for raddr_i, forwards same-cycle write
//           data (write-first), and forces zero for x0, disabled reads and
//           while a clear sweep is running.
// Ports   : raddr_i/re_i   read index and enable
//           busy_i         clear sweep in progress
//           we_i/waddr_i/wdata_i  write port seen this cycle (for forwarding)
//           regs_i         stored x1..x(REG_NUM-1)
//           rdata_o        read data, same cycle

module regs_rport
  import regs_pkg::*;
#(
  parameter int REG_NUM = 32
) (
  input  logic [ADDR_W-1:0]                 raddr_i,
  input  logic                              re_i,
  input  logic                              busy_i,
  input  logic                              we_i,
  input  logic [ADDR_W-1:0]                 waddr_i,
  input  logic [DATA_W-1:0]                 wdata_i,
  input  logic [REG_NUM-1:1][DATA_W-1:0]    regs_i,
  output logic [DATA_W-1:0]                 rdata_o
);

  always_comb begin
    rdata_o = `ZERO;
    if (re_i != `READ_ENABLE || raddr_i == `ZERO_REG || busy_i) begin
      rdata_o = `ZERO;
    end else if (we_i == `WRITE_ENABLE && waddr_i == raddr_i) begin
      // Write-first: the value being written this cycle wins over storage.
      rdata_o = wdata_i;
    end else begin
      rdata_o = regs_i[raddr_i];
    end
  end

endmodule

// File: rtl/regs.sv
// rtl/regs.sv - 2-read/1-write register file with sequential clear sweep
//
// Purpose : architectural register file x0..x(REG_NUM-1); x0 is hardwired to
//           zero and has no storage. A clr_i pulse starts a sweep that zeroes
//           one register per cycle from CLR_FIRST up to REG_NUM-1.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           reg1_raddr_i/re_i/rdata_o read port 1 (combinational)
//           reg2_raddr_i/re_i/rdata_o read port 2 (combinational)
//           reg_we_i/waddr_i/wdata_i  write port from writeback
//           clr_i                     start clear sweep (ignored while busy)
//           busy_o                    clear sweep in progress

module regs
  import regs_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int CLR_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg1_raddr_i,
  input  logic              reg1_re_i,
  output logic [DATA_W-1:0] reg1_rdata_o,
  input  logic [ADDR_W-1:0] reg2_raddr_i,
  input  logic              reg2_re_i,
  output logic [DATA_W-1:0] reg2_rdata_o,
  input  logic              reg_we_i,
  input  logic [ADDR_W-1:0] reg_waddr_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  input  logic              clr_i,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] CLR_IDX  = ADDR_W'(CLR_FIRST);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  state_t                           state_q, state_d;
  logic [ADDR_W-1:0]                cnt_q, cnt_d;
  logic                             clr_en;
  logic                             wr_en;
  logic [REG_NUM-1:1][DATA_W-1:0]   mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CLR_IDX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = CLR_IDX;
        end
      end
      CLEAR: begin
        // clr_i is not looked at here, so a repeat request cannot restart
        // or stretch the sweep.
        busy_o = 1'b1;
        clr_en = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = CLR_IDX;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CLR_IDX;
      end
    endcase
  end

  // Writes are only taken in IDLE, including the cycle that launches a sweep;
  // writes arriving during CLEAR are dropped rather than deferred.
  assign wr_en = (state_q == IDLE) && (reg_we_i == `WRITE_ENABLE) &&
                 (reg_waddr_i != `ZERO_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[reg_waddr_i] <= reg_wdata_i;
      end
      if (clr_en) begin
        mem_q[cnt_q] <= `ZERO;
      end
    end
  end

  regs_rport #(.REG_NUM(REG_NUM)) u_rport1 (
    .raddr_i (reg1_raddr_i),
    .re_i    (reg1_re_i),
    .busy_i  (busy_o),
    .we_i    (reg_we_i),
    .waddr_i (reg_waddr_i),
    .wdata_i (reg_wdata_i),
    .regs_i  (mem_q),
    .rdata_o (reg1_rdata_o)
  );

  regs_rport #(.REG_NUM(REG_NUM)) u_rport2 (
    .raddr_i (reg2_raddr_i),
    .re_i    (reg2_re_i),
    .busy_i  (busy_o),
    .we_i    (reg_we_i),
    .waddr_i (reg_waddr_i),
    .wdata_i (reg_wdata_i),
    .regs_i  (mem_q),
    .rdata_o (reg2_rdata_o)
  );

endmodule

// File: tb/tb_regs.sv
// tb/tb_regs.sv - self-checking bench for regs

module tb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, waddr;
  logic        re1, re2, we, clr;
  logic [31:0] wdata;
  logic [31:0] rd1, rd2;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regs dut (
    .clk          (clk),
    .rst          (rst),
    .reg1_raddr_i (ra1),
    .reg1_re_i    (re1),
    .reg1_rdata_o (rd1),
    .reg2_raddr_i (ra2),
    .reg2_re_i    (re2),
    .reg2_rdata_o (rd2),
    .reg_we_i     (we),
    .reg_waddr_i  (waddr),
    .reg_wdata_i  (wdata),
    .clr_i        (clr),
    .busy_o       (busy)
  );

  // Reference model: register contents plus the number of sweep cycles left.
  logic [31:0] exp_mem [32];
  int          sweep_left = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
      sweep_left = 0;
      chk_en = 1;
    end else if (sweep_left > 0) begin
      exp_mem[32 - sweep_left] = 32'h0;
      sweep_left--;
    end else begin
      if (we && waddr != 0) exp_mem[waddr] = wdata;
      if (clr) sweep_left = 31;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic e);
    if (!e || a == 0 || sweep_left > 0) return 32'h0;
    if (we && waddr == a) return wdata;
    return exp_mem[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model busy", {31'h0, busy}, (sweep_left > 0) ? 32'h1 : 32'h0);
      chk("model rdata1", rd1, exp_read(ra1, re1));
      chk("model rdata2", rd2, exp_read(ra2, re2));
    end
  end

  task automatic idle_in();
    rst = 0; clr = 0; we = 0; waddr = 0; wdata = 0;
    ra1 = 0; re1 = 0; ra2 = 0; re2 = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
  endtask

  int nbusy;

  initial begin
    idle_in();
    rst = 1;
    next_cycle();
    rst = 0;
    ra1 = 5; re1 = 1;
    @(negedge clk);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset read x5", rd1, 32'h0);

    // x5 write, then read with re=1 and re=0
    next_cycle();
    idle_in(); wr(5, 32'hDEADBEEF);
    next_cycle();
    idle_in(); ra1 = 5; re1 = 1;
    @(negedge clk);
    chk("x5 re=1", rd1, 32'hDEADBEEF);
    re1 = 0; #1;
    chk("x5 re=0", rd1, 32'h0);

    // same-cycle write forwarded to both ports
    next_cycle();
    idle_in(); wr(7, 32'h12345678); ra1 = 7; re1 = 1; ra2 = 7; re2 = 1;
    @(negedge clk);
    chk("fwd x7 p1", rd1, 32'h12345678);
    chk("fwd x7 p2", rd2, 32'h12345678);
    next_cycle();
    we = 0;
    @(negedge clk);
    chk("stored x7 p1", rd1, 32'h12345678);
    chk("stored x7 p2", rd2, 32'h12345678);

    // x0 is never written nor forwarded
    next_cycle();
    idle_in(); wr(0, 32'hFFFFFFFF); ra1 = 0; re1 = 1;
    @(negedge clk);
    chk("x0 write cycle", rd1, 32'h0);
    next_cycle();
    we = 0;
    @(negedge clk);
    chk("x0 after", rd1, 32'h0);

    // back-to-back writes to x4 observed on port 2
    next_cycle();
    idle_in(); wr(4, 32'h1); ra2 = 4; re2 = 1;
    @(negedge clk);
    chk("x4 first", rd2, 32'h1);
    next_cycle();
    wr(4, 32'h2);
    @(negedge clk);
    chk("x4 second", rd2, 32'h2);
    next_cycle();
    we = 0;
    @(negedge clk);
    chk("x4 stored", rd2, 32'h2);

    // fill x1..x31 with their index, then sweep
    for (int i = 1; i < 32; i++) begin
      next_cycle();
      idle_in(); wr(5'(i), 32'(i));
    end
    next_cycle();
    idle_in(); clr = 1; wr(2, 32'h77);
    @(negedge clk);
    chk("busy before sweep", {31'h0, busy}, 32'h0);
    nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      idle_in();
      clr = (nbusy == 5);
      if (nbusy == 10) wr(3, 32'hCAFE0003);
      @(negedge clk);
      if (busy) nbusy++;
    end
    chk("sweep length", 32'(nbusy), 32'd31);
    next_cycle();
    ra1 = 3; re1 = 1; ra2 = 31; re2 = 1;
    @(negedge clk);
    chk("x3 after sweep", rd1, 32'h0);
    chk("x31 after sweep", rd2, 32'h0);
    for (int i = 1; i < 32; i++) begin
      next_cycle();
      ra1 = 5'(i); ra2 = 5'(32 - i);
    end

    // reset in the middle of a sweep
    for (int i = 1; i < 32; i++) begin
      next_cycle();
      idle_in(); wr(5'(i), 32'(i) | 32'h100);
    end
    next_cycle();
    idle_in(); clr = 1;
    nbusy = 0;
    for (int c = 0; c < 40 && nbusy < 15; c++) begin
      next_cycle();
      idle_in();
      @(negedge clk);
      if (busy) nbusy++;
    end
    chk("reached sweep cycle 15", 32'(nbusy), 32'd15);
    next_cycle();
    rst = 1;
    next_cycle();
    idle_in(); ra1 = 30; re1 = 1; ra2 = 31; re2 = 1;
    @(negedge clk);
    chk("busy after abort", {31'h0, busy}, 32'h0);
    chk("x30 after abort", rd1, 32'h0);
    chk("x31 after abort", rd2, 32'h0);
    next_cycle();
    idle_in(); wr(9, 32'hA5A5A5A5);
    next_cycle();
    idle_in(); ra1 = 9; re1 = 1;
    @(negedge clk);
    chk("x9 after abort", rd1, 32'hA5A5A5A5);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      rst   = ($urandom_range(0, 299) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      we    = $urandom_range(0, 1);
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      re1   = ($urandom_range(0, 7) != 0);
      re2   = ($urandom_range(0, 7) != 0);
      ra1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      ra2   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
    end
    next_cycle();
    idle_in();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
